// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state encoding
// and default parameter values.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_W_DEF       = 8;
  localparam int unsigned CLK_DIV_DEFAULT_DIV = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } div_state_e;

endpackage

// File: rtl/clk_div_negq.sv
// Negedge retiming flop: delays the posedge phase by half a clkin period so
// odd ratios can produce a high time of N/2 cycles.
module clk_div_negq (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(negedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with glitch-free ratio updates applied
// only at period boundaries, a run/drain control FSM and an N==1 bypass.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned W           = CLK_DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_n,
  input  logic         div_load,
  output logic         clkout,
  output logic         tick,
  output logic         cfg_pend,
  output logic         cfg_err,
  output logic         running
);

  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W:0]   ONE_X = (W+1)'(1);

  div_state_e   r_state,    w_state_nxt;
  logic [W-1:0] r_cnt,      w_cnt_nxt;
  logic [W-1:0] r_div,      w_div_nxt;
  logic [W-1:0] r_pend_div, w_pend_div_nxt;
  logic         r_pend,     w_pend_nxt;
  logic         r_pq,       w_pq_nxt;
  logic         r_cfg_err;
  logic [W:0]   w_half;
  logic         w_wrap, w_apply, w_load_ok, w_bypass, w_nq, w_pq_to_neg;

  assign w_wrap    = (r_cnt == (r_div - ONE));
  // Idle applies a pending ratio straight away; otherwise only on the wrap.
  assign w_apply   = (r_state == ST_IDLE) || w_wrap;
  assign w_load_ok = div_load && (div_n != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = r_div;
    w_pend_nxt     = r_pend;
    w_pend_div_nxt = r_pend_div;

    if (w_apply) begin
      w_pend_nxt = 1'b0;
      if (r_pend) w_div_nxt = r_pend_div;
    end
    // A load landing on a boundary waits for the next one (last write wins).
    if (w_load_ok) begin
      w_pend_nxt     = 1'b1;
      w_pend_div_nxt = div_n;
    end

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_nxt = w_wrap ? '0 : r_cnt + ONE;
        if (!en) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_cnt_nxt = w_wrap ? '0 : r_cnt + ONE;
        if (en)          w_state_nxt = ST_RUN;
        else if (w_wrap) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_half   = ({1'b0, w_div_nxt} + ONE_X) >> 1;
    w_pq_nxt = (w_state_nxt != ST_IDLE) && ({1'b0, w_cnt_nxt} < w_half);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pq       <= 1'b0;
      r_div      <= W'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pq       <= w_pq_nxt;
      r_div      <= w_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_pend     <= w_pend_nxt;
      r_cfg_err  <= div_load && (div_n == '0);
    end
  end

  // Keep nq low during bypass so a switch to an odd ratio starts at the negedge.
  assign w_pq_to_neg = r_pq && (r_div != ONE);

  clk_div_negq u_negq (
    .i_clk (clkin),
    .i_rst (rst),
    .i_d   (w_pq_to_neg),
    .o_q   (w_nq)
  );

  assign w_bypass = (r_state != ST_IDLE) && (r_div == ONE);
  assign clkout   = w_bypass ? clkin : (r_div[0] ? (r_pq & w_nq) : r_pq);
  assign running  = (r_state != ST_IDLE);
  assign tick     = running && (r_cnt == '0);
  assign cfg_pend = r_pend;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a period-position reference model
// predicts every output per half clkin cycle; a monitor compares the DUT.
module tb_clk_div_prog;

  localparam int DEF_N = 5;

  logic       clkin = 1'b0;
  logic       rst, en, div_load;
  logic [7:0] div_n;
  logic       clkout, tick, cfg_pend, cfg_err, running;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit tick, run, pend, err, clk_hi, clk_lo;
    int n;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: period length, position inside the period, stop request.
  int m_n = DEF_N, m_pos = 0, m_pend_val = 0;
  bit m_run = 0, m_drain = 0, m_pend = 0, m_err = 0;

  clk_div_prog dut (
    .clkin    (clkin),
    .rst      (rst),
    .en       (en),
    .div_n    (div_n),
    .div_load (div_load),
    .clkout   (clkout),
    .tick     (tick),
    .cfg_pend (cfg_pend),
    .cfg_err  (cfg_err),
    .running  (running)
  );

  always #5 clkin = ~clkin;

  // Ideal divided clock at half-cycle index h = 2*pos + half.
  function automatic bit clk_ref(input int n, input int pos, input int half);
    int h;
    h = 2 * pos + half;
    if (n == 1)          return (half == 0);
    else if (n % 2 == 0) return (h < n);
    else                 return (h >= 1) && (h <= n);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit ld, input int dn);
    bit eop, bnd;
    int n_new;
    if (r) begin
      m_n = DEF_N; m_pos = 0; m_run = 0; m_drain = 0; m_pend = 0; m_err = 0;
      return;
    end
    eop   = m_run && (m_pos == m_n - 1);
    bnd   = !m_run || eop;
    n_new = (bnd && m_pend) ? m_pend_val : m_n;
    if (bnd) m_pend = 0;
    if (ld && dn != 0) begin m_pend = 1; m_pend_val = dn; end
    m_err = ld && (dn == 0);
    if (!m_run) begin
      if (e) begin m_run = 1; m_drain = 0; m_pos = 0; end
    end else begin
      m_pos = eop ? 0 : m_pos + 1;
      if (m_drain) begin
        if (e) m_drain = 0;
        else if (eop) begin m_run = 0; m_pos = 0; end
      end else if (!e) begin
        m_drain = 1;
      end
    end
    m_n = n_new;
  endtask

  // Model: advance on every posedge using the inputs the DUT samples.
  initial begin
    exp_t e;
    forever begin
      @(posedge clkin);
      model_step(rst, en, div_load, int'(div_n));
      e.tick   = m_run && (m_pos == 0);
      e.run    = m_run;
      e.pend   = m_pend;
      e.err    = m_err;
      e.clk_hi = m_run && clk_ref(m_n, m_pos, 0);
      e.clk_lo = m_run && clk_ref(m_n, m_pos, 1);
      e.n      = m_n;
      exp_q.push_back(e);
    end
  end

  // Monitor: first-half checks after posedge, clkout second half after negedge.
  initial begin
    exp_t e;
    bit   rst_neg, want_lo;
    int   cyc = 0;
    forever begin
      @(posedge clkin);
      #1;
      cyc++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cyc %0d scoreboard empty", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({tick, running, cfg_pend, cfg_err, clkout} !==
            {e.tick, e.run, e.pend, e.err, e.clk_hi}) begin
          n_err++;
          $display("FAIL cyc %0d tick/run/pend/err/clk got %b want %b", cyc,
                   {tick, running, cfg_pend, cfg_err, clkout},
                   {e.tick, e.run, e.pend, e.err, e.clk_hi});
        end
        @(negedge clkin);
        rst_neg = rst;
        #1;
        // A reset seen at the negedge clears the retiming flop, pulling odd-N clkout low.
        want_lo = e.clk_lo && !(rst_neg && (e.n % 2 == 1) && (e.n >= 3));
        n_vec++;
        if (clkout !== want_lo) begin
          n_err++;
          $display("FAIL cyc %0d clkout low-phase got %b want %b (N=%0d)", cyc,
                   clkout, want_lo, e.n);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clkin);
      #2;
      div_load = 1'b0;
    end
  endtask

  task automatic load(input int v);
    div_n    = 8'(v);
    div_load = 1'b1;
    cycles(1);
  endtask

  task automatic wait_pos(input int p, input int n);
    int k = 0;
    while (!(m_run && m_pos == p && m_n == n) && k < 60) begin
      cycles(1);
      k++;
    end
    if (k >= 60) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pos timeout got pos %0d N %0d want pos %0d N %0d", m_pos, m_n, p, n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_run && k < 300) begin
      cycles(1);
      k++;
    end
    if (k >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle timeout got run %b want 0", m_run);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_n = '0;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Default ratio 5 from reset.
    en = 1'b1;
    cycles(25);

    // Ratio 4 loaded mid-period, applied at the wrap.
    wait_pos(1, 5);
    load(4);
    cycles(20);

    // Zero ratio rejected.
    load(0);
    cycles(10);

    // Drain from cnt=1 at N=6, then a drain cancelled at cnt=3.
    load(6);
    wait_pos(1, 6);
    en = 1'b0;
    cycles(10);
    en = 1'b1;
    wait_pos(1, 6);
    en = 1'b0;
    wait_pos(3, 6);
    en = 1'b1;
    cycles(12);

    // Bypass with N=1, then back to an odd ratio.
    en = 1'b0;
    wait_idle();
    load(1);
    en = 1'b1;
    cycles(8);
    load(3);
    cycles(15);

    // Reset mid-period at N=7, restart with the default ratio.
    load(7);
    wait_pos(2, 7);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(14);

    // Randomised traffic.
    repeat (600) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 11) == 0) begin
        div_n    = 8'($urandom_range(0, 12));
        div_load = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      cycles(1);
      rst = 1'b0;
    end

    cycles(2);
    @(negedge clkin);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
